// File: rtl/audio_sample_feeder_pkg.sv
// Shared definitions for the audio sample feeder: feed FSM state encoding.
package audio_sample_feeder_pkg;

  // Encoding 2'd3 is unused and recovers to FEED_IDLE.
  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_ISSUE = 2'd1,
    FEED_WAIT  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/audio_sample_feeder_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level, sticky overflow and
// synchronous active-high reset. Read data is the current head (show-ahead).
module sync_fifo #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_DEPTH = DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_d;
  logic                  push;
  logic                  pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level;
    case ({push, pop})
      2'b10:   level_d = level + LVL_ONE;
      2'b01:   level_d = level - LVL_ONE;
      default: level_d = level;
    endcase
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (!aclr && push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, registered status flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_d;
      full  <= (level_d == LVL_DEPTH);
      empty <= (level_d == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Buffers stereo PCM samples and issues one sample per ready assertion of the
// output stage through a one-cycle wreq strobe; counts starvation events.
module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int unsigned AUDIO_BITS      = 12,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned CNT_BITS        = 16
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       wr_en,
  input  logic [2*AUDIO_BITS-1:0]    wr_data,
  output logic                       full,
  output logic [FIFO_DEPTH_LOG2:0]   level,
  output logic                       overflow,
  input  logic                       ready,
  output logic                       wreq,
  output logic [2*AUDIO_BITS-1:0]    sample,
  output logic [CNT_BITS-1:0]        underrun_count
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

  feed_state_t             state_q;
  feed_state_t             state_d;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [2*AUDIO_BITS-1:0] fifo_head;
  logic                    wreq_d;
  logic [2*AUDIO_BITS-1:0] sample_d;
  logic                    ready_q;
  logic [CNT_BITS-1:0]     underrun_d;

  sync_fifo #(
    .WIDTH      (2 * AUDIO_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .aclr     (aclr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level),
    .overflow (overflow)
  );

  // Feed FSM next state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    wreq_d   = 1'b0;
    sample_d = sample;
    case (state_q)
      FEED_IDLE: begin
        if (ready && !fifo_empty) begin
          fifo_pop = 1'b1;
          sample_d = fifo_head;
          wreq_d   = 1'b1;
          state_d  = FEED_ISSUE;
        end
      end
      FEED_ISSUE: state_d = FEED_WAIT;
      // A stale ready=1 must drop before the next issue is allowed.
      FEED_WAIT:  if (!ready) state_d = FEED_IDLE;
      default:    state_d = FEED_IDLE;
    endcase
  end

  // Saturating starvation counter on rising ready with an empty FIFO.
  always_comb begin
    underrun_d = underrun_count;
    if (ready && !ready_q && fifo_empty && (underrun_count != '1))
      underrun_d = underrun_count + CNT_ONE;
  end

  // State, registered outputs and ready history.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q        <= FEED_IDLE;
      wreq           <= 1'b0;
      sample         <= '0;
      ready_q        <= 1'b0;
      underrun_count <= '0;
    end else begin
      state_q        <= state_d;
      wreq           <= wreq_d;
      sample         <= sample_d;
      ready_q        <= ready;
      underrun_count <= underrun_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder with hand-computed expectations.
module tb_audio_sample_feeder;

  logic        clk;
  logic        aclr;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic        ready;
  logic        wreq;
  logic [23:0] sample;
  logic [15:0] underrun_count;

  logic        wr_en2;
  logic [23:0] wr_data2;
  logic        full2;
  logic [4:0]  level2;
  logic        overflow2;
  logic        ready2;
  logic        wreq2;
  logic [23:0] sample2;
  logic [1:0]  underrun_count2;

  int checks = 0;
  int errors = 0;

  audio_sample_feeder #(
    .AUDIO_BITS      (12),
    .FIFO_DEPTH_LOG2 (4),
    .CNT_BITS        (16)
  ) dut (
    .clk            (clk),
    .aclr           (aclr),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .level          (level),
    .overflow       (overflow),
    .ready          (ready),
    .wreq           (wreq),
    .sample         (sample),
    .underrun_count (underrun_count)
  );

  audio_sample_feeder #(
    .AUDIO_BITS      (12),
    .FIFO_DEPTH_LOG2 (4),
    .CNT_BITS        (2)
  ) dut_sat (
    .clk            (clk),
    .aclr           (aclr),
    .wr_en          (wr_en2),
    .wr_data        (wr_data2),
    .full           (full2),
    .level          (level2),
    .overflow       (overflow2),
    .ready          (ready2),
    .wreq           (wreq2),
    .sample         (sample2),
    .underrun_count (underrun_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] dval(input int i);
    return 24'(24'h100000 + i * 24'h000111);
  endfunction

  task automatic test_reset();
    aclr = 1'b1; ready = 1'b1;
    tick(); tick();
    checks++;
    if ({full, level, overflow, wreq, sample, underrun_count} !== {1'b0, 5'd0, 1'b0, 1'b0, 24'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got full=%b level=%0d ovf=%b wreq=%b sample=%h cnt=%0d, want all 0",
               full, level, overflow, wreq, sample, underrun_count);
    end
    aclr = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({wreq, sample, underrun_count, level} !== {1'b0, 24'd0, 16'd1, 5'd0}) begin
      errors++;
      $display("FAIL reset_ready_underrun: got wreq=%b sample=%h cnt=%0d level=%0d, want 0 000000 1 0",
               wreq, sample, underrun_count, level);
    end
  endtask

  task automatic test_single_issue();
    wr_en = 1'b1; wr_data = 24'hABC123;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({level, wreq} !== {5'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_push: got level=%0d wreq=%b, want 1 0", level, wreq);
    end
    tick();
    checks++;
    if ({wreq, sample, level} !== {1'b1, 24'hABC123, 5'd0}) begin
      errors++;
      $display("FAIL single_issue: got wreq=%b sample=%h level=%0d, want 1 abc123 0", wreq, sample, level);
    end
    tick();
    checks++;
    if ({wreq, sample} !== {1'b0, 24'hABC123}) begin
      errors++;
      $display("FAIL single_one_cycle: got wreq=%b sample=%h, want 0 abc123", wreq, sample);
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_paced_issue();
    logic [23:0] exp_s [3];
    logic [4:0]  exp_l [3];
    int extra;
    exp_s[0] = 24'h111222; exp_s[1] = 24'h333444; exp_s[2] = 24'h555666;
    exp_l[0] = 5'd2;       exp_l[1] = 5'd1;       exp_l[2] = 5'd0;
    ready = 1'b0;
    wr_en = 1'b1; wr_data = exp_s[0]; tick();
    wr_data = exp_s[1]; tick();
    wr_en = 1'b0;
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      ready = 1'b1;
      wr_en = (k == 0);
      wr_data = exp_s[2];
      tick();
      wr_en = 1'b0;
      checks++;
      if ({wreq, sample, level} !== {1'b1, exp_s[k], exp_l[k]}) begin
        errors++;
        $display("FAIL paced_issue_%0d: got wreq=%b sample=%h level=%0d, want 1 %h %0d",
                 k, wreq, sample, level, exp_s[k], exp_l[k]);
      end
      tick();
      if (wreq) extra++;
      ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (wreq) extra++;
      end
    end
    checks++;
    if ({extra, underrun_count} !== {32'd0, 16'd1}) begin
      errors++;
      $display("FAIL paced_no_extra: got extra_wreq=%0d cnt=%0d, want 0 1", extra, underrun_count);
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = dval(i);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill_16: got full=%b level=%0d ovf=%b, want 1 16 0", full, level, overflow);
    end
    wr_en = 1'b1; wr_data = dval(16);
    tick();
    checks++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL push_17_dropped: got full=%b level=%0d ovf=%b, want 1 16 1", full, level, overflow);
    end
    wr_data = dval(17); ready = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({full, level, wreq, sample} !== {1'b0, 5'd15, 1'b1, dval(0)}) begin
      errors++;
      $display("FAIL push_pop_full: got full=%b level=%0d wreq=%b sample=%h, want 0 15 1 %h",
               full, level, wreq, sample, dval(0));
    end
    ready = 1'b0;
    tick(); tick();
    for (int j = 1; j < 16; j++) begin
      ready = 1'b1;
      tick();
      checks++;
      if ({wreq, sample} !== {1'b1, dval(j)}) begin
        errors++;
        $display("FAIL drain_%0d: got wreq=%b sample=%h, want 1 %h", j, wreq, sample, dval(j));
      end
      ready = 1'b0;
      tick(); tick();
    end
    checks++;
    if ({level, full, overflow, underrun_count} !== {5'd0, 1'b0, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL drained_state: got level=%0d full=%b ovf=%b cnt=%0d, want 0 0 1 1",
               level, full, overflow, underrun_count);
    end
  endtask

  task automatic test_stale_ready();
    int extra;
    ready = 1'b0;
    wr_en = 1'b1; wr_data = 24'h5A5A5A; tick();
    wr_data = 24'hA5A5A5; tick();
    wr_en = 1'b0;
    ready = 1'b1;
    tick();
    checks++;
    if ({wreq, sample} !== {1'b1, 24'h5A5A5A}) begin
      errors++;
      $display("FAIL stale_first: got wreq=%b sample=%h, want 1 5a5a5a", wreq, sample);
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wreq) extra++;
    end
    ready = 1'b0;
    tick();
    if (wreq) extra++;
    checks++;
    if ({extra, level} !== {32'd0, 5'd1}) begin
      errors++;
      $display("FAIL stale_held: got extra_wreq=%0d level=%0d, want 0 1", extra, level);
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({wreq, sample, level, underrun_count} !== {1'b1, 24'hA5A5A5, 5'd0, 16'd1}) begin
      errors++;
      $display("FAIL stale_second: got wreq=%b sample=%h level=%0d cnt=%0d, want 1 a5a5a5 0 1",
               wreq, sample, level, underrun_count);
    end
    ready = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation_and_abort();
    logic [1:0] exp_c [5];
    int extra;
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      ready2 = 1'b1;
      tick();
      checks++;
      if (underrun_count2 !== exp_c[k]) begin
        errors++;
        $display("FAIL saturate_%0d: got cnt=%0d, want %0d", k, underrun_count2, exp_c[k]);
      end
      ready2 = 1'b0;
      tick();
    end
    ready = 1'b0;
    wr_en = 1'b1; wr_data = 24'h123456; tick();
    wr_data = 24'h654321; tick();
    wr_en = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({wreq, sample, level} !== {1'b0, 24'h123456, 5'd1}) begin
      errors++;
      $display("FAIL abort_setup: got wreq=%b sample=%h level=%0d, want 0 123456 1", wreq, sample, level);
    end
    aclr = 1'b1;
    tick();
    checks++;
    if ({full, level, overflow, wreq, sample, underrun_count} !== {1'b0, 5'd0, 1'b0, 1'b0, 24'd0, 16'd0}) begin
      errors++;
      $display("FAIL abort_reset: got full=%b level=%0d ovf=%b wreq=%b sample=%h cnt=%0d, want all 0",
               full, level, overflow, wreq, sample, underrun_count);
    end
    aclr = 1'b0; ready = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wreq) extra++;
    end
    checks++;
    if ({extra, level, underrun_count} !== {32'd0, 5'd0, 16'd0}) begin
      errors++;
      $display("FAIL abort_quiet: got extra_wreq=%0d level=%0d cnt=%0d, want 0 0 0", extra, level, underrun_count);
    end
  endtask

  initial begin
    aclr = 1'b1; wr_en = 1'b0; wr_data = '0; ready = 1'b0;
    wr_en2 = 1'b0; wr_data2 = '0; ready2 = 1'b0;
    test_reset();
    test_single_issue();
    test_paced_issue();
    test_overflow();
    test_stale_ready();
    test_saturation_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
